// File: rtl/rise_event_arbiter_pkg.sv
// Shared types and helpers for the rising-edge event arbiter.
// Optional drop counter is enabled with RISE_ARB_DROP_CNT_EN.
package rise_arb_pkg;

    localparam int MAX_N = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_N-1:0] v);
        int unsigned c;
        c = 32'd0;
        for (int i = 0; i < MAX_N; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/rise_event_arbiter_if.sv
// Single-event valid/ready channel carrying the granted channel index.
interface rise_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            out_valid;
    logic            out_ready;
    logic [ID_W-1:0] out_id;

    modport master (output out_valid, output out_id, input out_ready);
    modport slave  (input out_valid, input out_id, output out_ready);
endinterface

// File: rtl/rise_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping at N.
module rr_pick
    import rise_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic [ID_W-1:0] grant,
    output logic            any
);

    // Scan N positions from start; modular wrap keeps non-power-of-two N correct.
    always_comb begin
        int sum;
        int idx;
        sum   = 0;
        idx   = 0;
        grant = {ID_W{1'b0}};
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum   = int'(start) + k;
            idx   = (sum >= N) ? (sum - N) : sum;
            grant = (!any && req[idx]) ? ID_W'(idx) : grant;
            any   = any | req[idx];
        end
    end

endmodule

// File: rtl/rise_event_arbiter.sv
// Rising-edge event scheduler: latches rises per channel, offers them round-robin.
// Define RISE_ARB_DROP_CNT_EN to add the saturating drop_cnt output.
module rise_event_arbiter
    import rise_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in,
    rise_event_arbiter_if.master out_if
`ifdef RISE_ARB_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]     drop_cnt
`endif
);

    localparam int ID_W = id_width(N);

    if (N < 1 || N > MAX_N || CNT_W < 1) begin : g_bad_cfg
        $error("rise_event_arbiter: unsupported N or CNT_W");
    end

    logic [N-1:0]    prev_r;
    logic [N-1:0]    pending_r;
    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] out_id_r;
    logic            out_valid_r;
    arb_state_e      state_r;

    logic [N-1:0]    rise_s;
    logic [N-1:0]    grant_mask_s;
    logic [N-1:0]    pending_next_s;
    logic [ID_W-1:0] ptr_next_s;
    logic            hs_s;
    logic [ID_W-1:0] idle_grant_s;
    logic [ID_W-1:0] hs_grant_s;
    logic            idle_any_s;
    logic            hs_any_s;

    // Edge detect and next pending set; a rise on the granted channel re-arms it.
    always_comb begin
        rise_s         = in & ~prev_r;
        hs_s           = out_valid_r & out_if.out_ready;
        grant_mask_s   = hs_s ? (N'(1'b1) << out_id_r) : {N{1'b0}};
        pending_next_s = (pending_r & ~grant_mask_s) | rise_s;
        ptr_next_s     = (out_id_r == ID_W'(N - 1)) ? {ID_W{1'b0}} : (out_id_r + ID_W'(1'b1));
    end

    rr_pick #(.N(N)) u_pick_idle (
        .req   (pending_r),
        .start (ptr_r),
        .grant (idle_grant_s),
        .any   (idle_any_s)
    );

    rr_pick #(.N(N)) u_pick_hs (
        .req   (pending_next_s),
        .start (ptr_next_s),
        .grant (hs_grant_s),
        .any   (hs_any_s)
    );

    // Offer FSM with registered valid/id; a handshake may chain straight into the next offer.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r      <= {N{1'b0}};
            pending_r   <= {N{1'b0}};
            ptr_r       <= {ID_W{1'b0}};
            out_id_r    <= {ID_W{1'b0}};
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
        end else begin
            prev_r    <= in;
            pending_r <= pending_next_s;
            case (state_r)
                IDLE: begin
                    if (idle_any_s) begin
                        out_id_r    <= idle_grant_s;
                        out_valid_r <= 1'b1;
                        state_r     <= OFFER;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                OFFER: begin
                    if (hs_s) begin
                        ptr_r <= ptr_next_s;
                        if (hs_any_s) begin
                            out_id_r <= hs_grant_s;
                        end else begin
                            out_valid_r <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign out_if.out_valid = out_valid_r;
    assign out_if.out_id    = out_id_r;

`ifdef RISE_ARB_DROP_CNT_EN
    logic [N-1:0]       drop_s;
    logic [CNT_W+6:0]   drop_sum_s;
    logic [CNT_W-1:0]   drop_cnt_r;

    // A rise on an already pending, non-granted channel is lost.
    always_comb begin
        drop_s     = rise_s & pending_r & ~grant_mask_s;
        drop_sum_s = {7'd0, drop_cnt_r} + (CNT_W + 7)'(popcount(MAX_N'(drop_s)));
    end

    // Saturating accumulation of per-cycle drop counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= {CNT_W{1'b0}};
        end else if (drop_sum_s > {7'd0, {CNT_W{1'b1}}}) begin
            drop_cnt_r <= {CNT_W{1'b1}};
        end else begin
            drop_cnt_r <= drop_sum_s[CNT_W-1:0];
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
`endif

endmodule

// File: tb/tb_rise_event_arbiter.sv
// Scoreboard bench for rise_event_arbiter: directed test-plan phases plus random traffic.
module tb_rise_event_arbiter;
    import rise_arb_pkg::*;

    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int ID_W  = id_width(N);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] in_v = '0;
`ifdef RISE_ARB_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt;
`endif

    rise_event_arbiter_if #(.ID_W(ID_W)) bus ();

    rise_event_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_v),
        .out_if   (bus)
`ifdef RISE_ARB_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int got_q[$];

    // reference model state
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_prev = '0;
    int           m_ptr = 0;
    int           m_id = 0;
    bit           m_valid = 1'b0;
    int           m_drop = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] p, input int start);
        for (int k = 0; k < N; k++) begin
            if (p[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] old_pend;
        logic [N-1:0] rise;
        bit hs;
        int nd;
        int k;
        if (rst) begin
            m_pend = '0; m_prev = '0; m_ptr = 0; m_id = 0; m_valid = 1'b0; m_drop = 0;
            exp_q.delete();
        end else begin
            old_pend = m_pend;
            rise = in_v & ~m_prev;
            hs = m_valid && bus.out_ready;
            nd = 0;
            for (int i = 0; i < N; i++) begin
                if (rise[i] && m_pend[i] && !(hs && i == m_id)) nd++;
            end
            m_drop = (m_drop + nd > CMAX) ? CMAX : m_drop + nd;
            if (hs) begin
                exp_q.push_back(m_id);
                m_pend[m_id] = 1'b0;
            end
            m_pend = m_pend | rise;
            if (!m_valid) begin
                k = first_from(old_pend, m_ptr);
                if (k >= 0) begin m_id = k; m_valid = 1'b1; end
            end else if (hs) begin
                m_ptr = (m_id + 1) % N;
                k = first_from(m_pend, m_ptr);
                if (k >= 0) m_id = k;
                else m_valid = 1'b0;
            end
            m_prev = in_v;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: handshake is judged mid-cycle, checked after the edge the model has processed.
    initial begin
        bit hs_seen;
        int hs_id;
        hs_seen = 1'b0;
        hs_id = 0;
        forever begin
            @(negedge clk);
            #2;
            hs_seen = bus.out_valid && bus.out_ready && !rst;
            hs_id = int'(bus.out_id);
            @(posedge clk);
            #1;
            if (hs_seen) begin
                got_q.push_back(hs_id);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_grant: got id %0d, expected no handshake at %0t", hs_id, $time);
                end else begin
                    chk("grant_id", hs_id, exp_q.pop_front());
                end
            end
            chk("out_valid", int'(bus.out_valid), int'(m_valid));
            if (m_valid) chk("out_id", int'(bus.out_id), m_id);
`ifdef RISE_ARB_DROP_CNT_EN
            chk("drop_cnt", int'(drop_cnt), m_drop);
`endif
        end
    end

    task automatic do_reset();
        @(negedge clk);
        in_v = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic expect_seq(input string name, input int n, input int s0, input int s1,
                              input int s2, input int s3);
        int s[4];
        s = '{s0, s1, s2, s3};
        chk({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) chk({name, "_order"}, got_q[i], s[i]);
        got_q.delete();
    endtask

    initial begin
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // single event, latency
        do_reset();
        in_v = 4'b0001; bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        expect_seq("single", 1, 0, 0, 0, 0);

        // simultaneous rises, back-to-back
        do_reset();
        in_v = 4'b1111; bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        expect_seq("all4", 4, 0, 1, 2, 3);

        // hold during stall, then round-robin
        do_reset();
        in_v = 4'b1101; bus.out_ready = 1'b0;
        repeat (7) @(negedge clk);
        chk("stall_id", int'(bus.out_id), 0);
        expect_seq("stall", 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        expect_seq("hold_rr", 3, 0, 2, 3, 0);

        // pointer at 3: channel 3 served before 0
        do_reset();
        in_v = 4'b0100; bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        expect_seq("ptr_setup", 1, 2, 0, 0, 0);
        in_v = 4'b0000; bus.out_ready = 1'b0;
        @(negedge clk);
        in_v = 4'b1001;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        expect_seq("ptr_wrap", 2, 3, 0, 0, 0);

        // drop on a pending channel
        do_reset();
        in_v = 4'b0010; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        in_v = 4'b0000;
        @(negedge clk);
        in_v = 4'b0010;
        repeat (2) @(negedge clk);
`ifdef RISE_ARB_DROP_CNT_EN
        chk("drop_one", int'(drop_cnt), 1);
`endif
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        expect_seq("drop", 1, 1, 0, 0, 0);

        // re-rise on the handshake cycle is a new event
        do_reset();
        in_v = 4'b0100; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        in_v = 4'b0000;
        @(negedge clk);
        in_v = 4'b0100; bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        expect_seq("rerise", 2, 2, 2, 0, 0);
`ifdef RISE_ARB_DROP_CNT_EN
        chk("rerise_nodrop", int'(drop_cnt), 0);
`endif

        // reset mid-offer with input held high
        do_reset();
        in_v = 4'b0100; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_valid", int'(bus.out_valid), 0);
        rst = 1'b0; bus.out_ready = 1'b1;
        got_q.delete();
        repeat (5) @(negedge clk);
        expect_seq("post_reset", 1, 2, 0, 0, 0);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_v = N'($urandom);
            bus.out_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(99) == 0);
        end
        @(negedge clk);
        rst = 1'b0; in_v = '0; bus.out_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_idle", int'(bus.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
